// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] FAULT_WORD       = 32'h0FFF_FFFF;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID outputs.
interface fetch_pc_unit_if;

  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_data_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        fetch_fault_o;
  logic [31:0] fetch_count_o;

  // master: the fetch unit itself
  modport master (
    input  stall_i, flush_i, redirect_valid_i, redirect_target_i, instr_data_i,
    output instr_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
           fetch_fault_o, fetch_count_o
  );

  // slave: pipeline / memory environment around the fetch unit
  modport slave (
    output stall_i, flush_i, redirect_valid_i, redirect_target_i, instr_data_i,
    input  instr_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
           fetch_fault_o, fetch_count_o
  );

endinterface

// File: rtl/fetch_pc_unit_ifid_reg.sv
// IF/ID pipeline register: clear (to invalid/NOP) beats load, otherwise holds.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [31:0] instr_d,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP_WORD;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= pc_d;
      pc_plus4 <= pc_plus4_d;
      instr    <= instr_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage controller: PC, BOOT/RUN/FAULT sequencing, fault flag and delivery counter.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  fetch_pc_unit_if.master  bus
);

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_FAULT = FAULT;

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_seq;
  logic [31:0] count_q;
  logic        fault_q;
  logic        fault_hit;
  logic        ifid_load;
  logic        ifid_clear;

  assign pc_seq    = pc_q + PC_STEP;
  assign fault_hit = (bus.instr_data_i == FAULT_WORD);

  assign bus.instr_addr_o  = pc_q;
  assign bus.fetch_fault_o = fault_q;
  assign bus.fetch_count_o = count_q;

  // In FAULT the register is already invalid, so neither load nor clear is needed.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    case (state_q)
      ST_BOOT: ifid_clear = 1'b1;
      ST_RUN: begin
        if (bus.redirect_valid_i)                 ifid_clear = 1'b1;
        else if (bus.stall_i)                     ifid_clear = bus.flush_i;
        else if (fault_hit || bus.flush_i)        ifid_clear = 1'b1;
        else                                      ifid_load  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (bus.redirect_valid_i) begin
            pc_q <= bus.redirect_target_i;
          end else if (!bus.stall_i) begin
            if (fault_hit) begin
              fault_q <= 1'b1;
              state_q <= ST_FAULT;
            end else begin
              pc_q <= pc_seq;
            end
          end
        end
        ST_FAULT: begin
          if (bus.redirect_valid_i) begin
            pc_q    <= bus.redirect_target_i;
            fault_q <= 1'b0;
            state_q <= ST_BOOT;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
      if (ifid_load) count_q <= count_q + 32'd1;
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .pc_d       (pc_q),
    .pc_plus4_d (pc_seq),
    .instr_d    (bus.instr_data_i),
    .valid      (bus.ifid_valid_o),
    .pc         (bus.ifid_pc_o),
    .pc_plus4   (bus.ifid_pc_plus4_o),
    .instr      (bus.ifid_instr_o)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized check of fetch_pc_unit against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] FAULT_W = 32'h0FFF_FFFF;

  logic clk;
  logic rst;
  fetch_pc_unit_if bus();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n_checks = 0;

  logic [31:0] mem_ovr [logic [31:0]];

  // reference model: what the pipeline should look like after each edge
  logic [31:0] m_pc, m_ipc, m_iinstr, m_cnt;
  bit          m_boot, m_fault, m_v;

  function automatic logic [31:0] memw(logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'd7 + 32'h1357) | 32'h8000_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit st, bit fl, bit rv, logic [31:0] tg);
    logic [31:0] w;
    rst = r;
    bus.stall_i = st;
    bus.flush_i = fl;
    bus.redirect_valid_i = rv;
    bus.redirect_target_i = tg;
    if ($isunknown(bus.instr_addr_o)) bus.instr_data_i = '0;
    else bus.instr_data_i = memw(bus.instr_addr_o);
    w = memw(m_pc);
    if (r) begin
      m_pc = 32'h0; m_boot = 1; m_fault = 0; m_v = 0;
      m_ipc = 0; m_iinstr = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_v = 0; m_iinstr = 0;
    end else if (m_fault) begin
      if (rv) begin m_pc = tg; m_fault = 0; m_boot = 1; end
    end else if (rv) begin
      m_pc = tg; m_v = 0; m_iinstr = 0;
    end else if (st) begin
      if (fl) begin m_v = 0; m_iinstr = 0; end
    end else if (w == FAULT_W) begin
      m_v = 0; m_iinstr = 0; m_fault = 1;
    end else if (fl) begin
      m_v = 0; m_iinstr = 0; m_pc = m_pc + 4;
    end else begin
      m_v = 1; m_ipc = m_pc; m_iinstr = w; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    vectors++;
    chk("instr_addr", bus.instr_addr_o, m_pc);
    chk("ifid_valid", {31'b0, bus.ifid_valid_o}, {31'b0, m_v});
    chk("ifid_instr", bus.ifid_instr_o, m_iinstr);
    chk("fetch_fault", {31'b0, bus.fetch_fault_o}, {31'b0, m_fault});
    chk("fetch_count", bus.fetch_count_o, m_cnt);
    if (m_v || r) begin
      chk("ifid_pc", bus.ifid_pc_o, m_ipc);
      chk("ifid_pc_plus4", bus.ifid_pc_plus4_o, m_v ? m_ipc + 32'd4 : 32'h0);
    end
  endtask

  initial begin
    bit st, fl, rv, r;
    logic [31:0] tg;
    rst = 1'b1;
    bus.stall_i = 0; bus.flush_i = 0; bus.redirect_valid_i = 0;
    bus.redirect_target_i = '0; bus.instr_data_i = '0;
    m_pc = 0; m_ipc = 0; m_iinstr = 0; m_cnt = 0; m_boot = 1; m_fault = 0; m_v = 0;
    mem_ovr[32'h0] = 32'hA000_00AA;
    mem_ovr[32'h4] = 32'h1000_0011;
    mem_ovr[32'h8] = 32'h2000_0022;
    mem_ovr[32'h28] = FAULT_W;

    // reset, boot, then sequential fetch with stalls
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("count_after_three", bus.fetch_count_o, 32'd3);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("stall_flush_pc", bus.instr_addr_o, 32'h10);
    // redirect wins over stall and flush
    step(0, 1, 1, 1, 32'h20);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // fault at 0x28, frozen, then recover via redirect
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("recovered_pc0", bus.ifid_pc_o, 32'h0);
    // reset mid-stall with redirect pending
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pre_reset_pc", bus.instr_addr_o, 32'h14);
    step(1, 1, 1, 1, 32'h40);

    mem_ovr[32'h60] = FAULT_W;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 7) == 0);
      tg = 32'($urandom_range(0, 63)) << 2;
      step(r, st, fl, rv, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage controller of the MIPS pipeline: owns the program counter, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register for decode. Applies hazard-unit stalls, branch/jump redirects from later stages, and IF/ID flushes. Halts fetch when the instruction memory returns the unmapped-address word.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded by reset.
- PC_STEP, 4: sequential PC increment in bytes.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous, active-high.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- flush_i  in  1  invalidate IF/ID on this edge.
- redirect_valid_i  in  1  branch/jump taken.
- redirect_target_i  in  32  new PC.
- instr_addr_o  out  32  address to instruction memory; equals pc_q.
- instr_data_i  in  32  combinational read data for instr_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  32  PC of captured instruction.
- ifid_pc_plus4_o  out  32  ifid_pc_o + PC_STEP.
- ifid_instr_o  out  32  captured instruction; 32'h0 (NOP) when invalid.
- fetch_fault_o  out  1  sticky: unmapped fetch seen, fetch halted.
- fetch_count_o  out  32  instructions delivered into IF/ID.

## Operation
- States: BOOT, RUN, FAULT.
- BOOT: entered on rst. Next edge -> RUN, PC unchanged, IF/ID captures nothing (valid 0). Gives memory one cycle at RESET_PC.
- RUN, per edge, priority redirect > stall > normal:
  - redirect: pc_q <= redirect_target_i; IF/ID valid 0, instr NOP; overrides stall and flush.
  - stall (no redirect): pc_q and IF/ID hold; if flush_i also set, IF/ID valid 0 / NOP, PC still holds.
  - normal: pc_q <= pc_q + PC_STEP (mod 2^32); IF/ID <= {pc_q, pc_q+PC_STEP, instr_data_i}, valid 1, unless flush_i, then valid 0 / NOP.
  - instr_data_i == 32'h0FFF_FFFF (FAULT_WORD) on a normal capture: word not captured (valid 0, NOP), PC holds, fetch_fault_o <= 1, -> FAULT.
- FAULT: PC, IF/ID frozen at invalid/NOP; stall/flush ignored. redirect -> pc_q <= target, fetch_fault_o <= 0, -> BOOT.
- fetch_count_o increments by 1 each edge IF/ID is written with valid 1; wraps 2^32-1 -> 0.
- Invalid IF/ID always presents ifid_instr_o = 0 so decode sees NOP.

## Timing
- Reset values: pc_q = RESET_PC, instr_addr_o = RESET_PC, ifid_valid_o 0, ifid_pc_o 0, ifid_pc_plus4_o 0, ifid_instr_o 0, fetch_fault_o 0, fetch_count_o 0, state BOOT.
- instr_addr_o combinational from pc_q; no added latency.
- Fetch latency: PC value at cycle N appears in IF/ID after edge N+1 (one cycle).
- After rst deasserts at edge E: BOOT for one cycle; first valid IF/ID at edge E+2.
- Redirect sampled at edge N: pc_q = target after N; target instruction valid in IF/ID after N+1.
- rst mid-operation (any state, any stall/redirect): next edge forces all reset values.

## Structure
- Shared fetch_pkg: RESET_PC default, PC_STEP, FAULT_WORD = 32'h0FFF_FFFF, NOP_WORD = 32'h0, state enum {BOOT, RUN, FAULT}.
- One sub-module: ifid_reg (hold/load/clear register for valid, pc, pc_plus4, instr); PC, FSM, fault and counter stay in top.

## Test plan
- Reset then run, memory returns 0xA00000AA, 0x10000011, 0x20000022 at 0, 4, 8 -> IF/ID valid from 2nd edge after reset: (pc 0, 0xA00000AA), (4, 0x10000011), (8, 0x20000022); fetch_count 3.
- stall_i high 2 cycles at pc_q=8 -> pc_q and IF/ID unchanged 2 cycles, fetch_count unchanged; resumes at 0xC.
- redirect to 0x20 together with stall_i and flush_i -> pc_q=0x20, IF/ID valid 0 / instr 0; next edge IF/ID pc 0x20 valid 1.
- stall_i + flush_i at pc_q=0x10 -> IF/ID valid 0 / NOP, pc_q stays 0x10.
- memory returns 0x0FFFFFFF at pc 0x28 -> fetch_fault 1, pc_q frozen 0x28, IF/ID invalid; stall/flush no effect; redirect to 0x0 -> fault 0, BOOT, valid instruction at pc 0 two edges later.
- rst asserted mid-stall with pc_q=0x14, fetch_count 5 -> all outputs reset values next edge; pc_q=RESET_PC.
